// File: rtl/fft_agu_ctrl_if.sv
// Control and memory-address bundle of the radix-2 FFT address-generation unit.
// The stall input exists only when FFT_AGU_STALL_EN is defined.
interface fft_agu_ctrl_if #(parameter int M = 9);
  logic         start;
`ifdef FFT_AGU_STALL_EN
  logic         stall;
`endif
  logic         busy;
  logic         done;
  logic         rd_en;
  logic [M-1:0] rd_addr_a;
  logic [M-1:0] rd_addr_b;
  logic [M-2:0] twiddle_addr;
  logic         wr_en;
  logic [M-1:0] wr_addr_a;
  logic [M-1:0] wr_addr_b;
  logic         rd_bank;
  logic         result_bank;
  logic [1:0]   state_dbg;

  modport master (
    input  start,
`ifdef FFT_AGU_STALL_EN
    input  stall,
`endif
    output busy, done, rd_en, rd_addr_a, rd_addr_b, twiddle_addr,
           wr_en, wr_addr_a, wr_addr_b, rd_bank, result_bank, state_dbg
  );

  modport slave (
    output start,
`ifdef FFT_AGU_STALL_EN
    output stall,
`endif
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, twiddle_addr,
           wr_en, wr_addr_a, wr_addr_b, rd_bank, result_bank, state_dbg
  );
endinterface

// File: rtl/fft_agu_ctrl.sv
// Address generator and ping-pong bank scheduler for an in-place radix-2 N-point FFT.
// Optional feature macro: FFT_AGU_STALL_EN (adds a stall input that freezes butterfly issue).
module fft_agu_ctrl #(
  parameter int N        = 512,
  parameter int M        = 9,
  parameter int BFLY_LAT = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  fft_agu_ctrl_if.master bus
);

  localparam int SW = $clog2(M);
  localparam int LW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam logic [M-2:0] BFLY_LAST  = (M-1)'(N/2 - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(M - 1);
  localparam logic [LW-1:0] DRAIN_LAST = LW'(BFLY_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Handshake: start is a one-cycle request honoured only in IDLE; busy is high
  // from the cycle after acceptance through the done pulse. rd_en / wr_en are
  // single-cycle strobes qualifying the address buses they accompany, with no
  // back-pressure from the RAMs.
  state_e                     state_q, state_d;
  logic [M-2:0]               bfly_q, bfly_d;
  logic [SW-1:0]              stage_q, stage_d;
  logic [LW-1:0]              drain_q, drain_d;
  logic                       rd_bank_q, rd_bank_d;
  logic                       result_bank_q, result_bank_d;
  logic [BFLY_LAT-1:0]        dl_vld_q, dl_vld_d;
  logic [BFLY_LAT-1:0][M-1:0] dl_a_q, dl_a_d;
  logic [BFLY_LAT-1:0][M-1:0] dl_b_q, dl_b_d;

  logic                       stall_w;
  logic                       issue;
  logic [M-1:0]               rd_a, rd_b;
  logic [M-2:0]               tw;
  logic [2*M-3:0]             tw_mask;

`ifdef FFT_AGU_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  function automatic logic [M-1:0] rotl(input logic [M-1:0] x, input logic [SW-1:0] s);
    logic [SW:0] rs;
    rs = (SW+1)'(M) - {1'b0, s};
    return (x << s) | (x >> rs);
  endfunction

  assign issue = (state_q == RUN) && !stall_w;

  // Stage s pairs indices differing in bit s: a stage-0 style pair rotated left by s.
  always_comb begin
    rd_a    = '0;
    rd_b    = '0;
    tw      = '0;
    tw_mask = {{(M-1){1'b0}}, {(M-1){1'b1}}} << (STAGE_LAST - stage_q);
    if (issue) begin
      rd_a = rotl({bfly_q, 1'b0}, stage_q);
      rd_b = rotl({bfly_q, 1'b1}, stage_q);
      tw   = bfly_q & tw_mask[M-2:0];
    end
  end

  // Bubbles push zeros, so the write side reads all-zero whenever wr_en is low.
  always_comb begin
    dl_vld_d    = '0;
    dl_a_d      = '0;
    dl_b_d      = '0;
    dl_vld_d[0] = issue;
    dl_a_d[0]   = rd_a;
    dl_b_d[0]   = rd_b;
    for (int i = 1; i < BFLY_LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_a_d[i]   = dl_a_q[i-1];
      dl_b_d[i]   = dl_b_q[i-1];
    end
  end

  always_comb begin
    state_d       = state_q;
    bfly_d        = bfly_q;
    stage_d       = stage_q;
    drain_d       = drain_q;
    rd_bank_d     = rd_bank_q;
    result_bank_d = result_bank_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          bfly_d    = '0;
          stage_d   = '0;
          rd_bank_d = 1'b0;
        end
      end
      RUN: begin
        if (issue) begin
          bfly_d = bfly_q + (M-1)'(1);
          if (bfly_q == BFLY_LAST) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        // Leave once the stage's last write is on the outputs, so stages never overlap.
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d       = FINISH;
            result_bank_d = ~rd_bank_q;
          end else begin
            state_d   = RUN;
            stage_d   = stage_q + SW'(1);
            rd_bank_d = ~rd_bank_q;
            bfly_d    = '0;
          end
        end else begin
          drain_d = drain_q + LW'(1);
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bfly_q        <= '0;
      stage_q       <= '0;
      drain_q       <= '0;
      rd_bank_q     <= 1'b0;
      result_bank_q <= 1'b0;
      dl_vld_q      <= '0;
      dl_a_q        <= '0;
      dl_b_q        <= '0;
    end else begin
      state_q       <= state_d;
      bfly_q        <= bfly_d;
      stage_q       <= stage_d;
      drain_q       <= drain_d;
      rd_bank_q     <= rd_bank_d;
      result_bank_q <= result_bank_d;
      dl_vld_q      <= dl_vld_d;
      dl_a_q        <= dl_a_d;
      dl_b_q        <= dl_b_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == FINISH);
  assign bus.rd_en        = issue;
  assign bus.rd_addr_a    = rd_a;
  assign bus.rd_addr_b    = rd_b;
  assign bus.twiddle_addr = tw;
  assign bus.wr_en        = dl_vld_q[BFLY_LAT-1];
  assign bus.wr_addr_a    = dl_a_q[BFLY_LAT-1];
  assign bus.wr_addr_b    = dl_b_q[BFLY_LAT-1];
  assign bus.rd_bank      = rd_bank_q;
  assign bus.result_bank  = result_bank_q;
  assign bus.state_dbg    = state_q;

endmodule
